rs_issue_scheduler: RTL and testbench
=====================================

// Module: rs_issue_scheduler
// PURPOSE
//  Controller for the RS entry array: allocates one free entry per cycle to dispatch and raises its wr_en.
//  Selects one ready entry per FU channel per cycle, oldest-first, and drives that entry's clear.
//  Registers the selection for the issue stage.
//  Sits between decode/dispatch, the RS entry array and the FU issue stage.
// PARAMETERS
//  RS_SIZE   8   number of RS entries scheduled
//  NUM_CH    4   number of FU channels; channel codes come from the shared package
// PORTS
//  clock         in   1              system clock, rising edge
//  reset         in   1              asynchronous, active-high; clears all state
//  squash        in   1              synchronous flush, same effect as reset
//  dispatch_req  in   1              decode has a valid instruction to place
//  entry_busy    in   RS_SIZE        busy flags from the RS entries
//  entry_ready   in   RS_SIZE        ready flags from the RS entries
//  entry_ch      in   RS_SIZE x CH_W channel held by each entry
//  fu_avail      in   NUM_CH         FU of that channel accepts an issue this cycle
//  wr_en         out  RS_SIZE        one-hot write enable to the allocated entry
//  dispatch_ack  out  1              dispatch accepted this cycle
//  rs_full       out  1              occupancy == RS_SIZE; decode stalls
//  clear         out  RS_SIZE        entries selected this cycle; each frees next cycle
//  issue_valid   out  NUM_CH         registered: an entry was issued on that channel
//  issue_idx     out  NUM_CH x IDX_W registered index of the issued entry per channel
// BEHAVIOUR
//  Reset values: wr_en=0, dispatch_ack=0, rs_full=0, clear=0, issue_valid=0, issue_idx=0.
//  Internal reset state: age matrix = 0, occ_cnt = 0.
//  Allocation (combinational on registered state):
//   - dispatch_ack = dispatch_req & (occ_cnt < RS_SIZE).
//   - wr_en = lowest-index entry with entry_busy=0, gated by dispatch_ack.
//   - No bypass of a same-cycle clear: a full RS rejects dispatch even if an entry is issuing.
//  Age matrix: older[i][j] = 1 means i is older than j.
//   - On allocation of k: older[j][k] <= entry_busy[j] for all j, and older[k][*] <= 0.
//   - An entry cleared this cycle has its row and column zeroed.
//  Selection, per channel c:
//   - Candidate i: entry_busy[i] & entry_ready[i] & entry_ch[i]==c & fu_avail[c].
//   - Pick the candidate with no older candidate on the same channel; that entry's clear[i]=1 this cycle.
//   - At most one clear per channel; clear is one-hot within each channel.
//   - An entry being allocated this cycle is never selected (its busy flag is 0).
//  Issue register: issue_valid[c]/issue_idx[c] <= selection at the clock edge.
//   - 1-cycle latency from ready to issue_valid; deasserted on cycles with no selection.
//  occ_cnt <= occ_cnt + dispatch_ack - popcount(clear). Width clog2(RS_SIZE+1); never wraps.
//  rs_full = (occ_cnt == RS_SIZE), derived from the registered count.
//  Simultaneous alloc and issue: both take effect; the count nets them.
//  Squash: next edge clears age matrix, occ_cnt and issue_valid.
//   - wr_en and clear are forced to 0 during the squash cycle.
//  Reset mid-operation: asynchronous clear of all registers; outputs go to reset values immediately.
//  Invariant, asserted in simulation: occ_cnt == popcount(entry_busy) one cycle after any update.
// STRUCTURE
//  Shared package: CHANNEL enum (ALU, MULT, LOAD, STORE), RS_SIZE, NUM_CH, IDX_W, CH_W.
//  Shared package: ISSUE_SEL_PACKET {valid, idx}.
//  Sub-module rs_age_select: one per channel; takes the candidate mask and the age matrix,
//   returns a one-hot oldest entry. Generated NUM_CH times.
// TESTING
//  1. Reset, then 8 back-to-back dispatch_req -> wr_en = 1,2,4..128 one per cycle.
//     9th request: rs_full=1, dispatch_ack=0.
//  2. Entries 5 and 2 allocated in that order, both ALU and ready, fu_avail[ALU]=1.
//     -> clear=0x20, then issue_valid[ALU]=1 with idx=5. Next cycle, idx=2.
//  3. Ready entries on ALU (idx1) and MULT (idx3) in the same cycle.
//     -> clear=0x0A; next cycle both issue_valid bits set with idx 1 and 3.
//  4. RS full, entry 4 issues while dispatch_req=1 -> that cycle dispatch_ack=0.
//     Next cycle wr_en=0x10, occ_cnt stays 8.
//  5. fu_avail[ALU]=0 with ready ALU entries -> clear=0 and issue_valid[ALU]=0.
//     Raising fu_avail -> oldest entry issues.
//  6. Squash with 6 entries busy, then reset asserted mid-cycle.
//     -> occ_cnt=0, issue_valid=0; outputs zero asynchronously on reset.

Source files
------------

// File: rtl/rs_issue_scheduler_pkg.sv
// Shared types and sizes for the RS issue scheduler.
// Channel codes, issue selection packet and index helper.
package rs_issue_scheduler_pkg;

    localparam int RS_SIZE = 8;
    localparam int NUM_CH  = 4;
    localparam int IDX_W   = $clog2(RS_SIZE);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int CNT_W   = $clog2(RS_SIZE + 1);

    typedef enum logic [CH_W-1:0] {
        CH_ALU   = 2'd0,
        CH_MULT  = 2'd1,
        CH_LOAD  = 2'd2,
        CH_STORE = 2'd3
    } channel_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } issue_sel_t;

    function automatic logic [IDX_W-1:0] oh_to_idx(
        input logic [RS_SIZE-1:0] oh
    );
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rs_issue_scheduler_age_select.sv
// Oldest-first picker: returns a one-hot grant of the candidate
// that has no older candidate according to the age matrix.
module rs_age_select
    import rs_issue_scheduler_pkg::*;
(
    input  logic [RS_SIZE-1:0]         cand,
    input  logic [RS_SIZE*RS_SIZE-1:0] older,
    output logic [RS_SIZE-1:0]         grant
);

    logic [RS_SIZE-1:0] win;
    logic               found;

    always_comb begin
        win   = '0;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < RS_SIZE; i++) begin
            win[i] = cand[i];
            for (int j = 0; j < RS_SIZE; j++) begin
                if (cand[j] && older[j*RS_SIZE+i]) win[i] = 1'b0;
            end
        end
        // Lowest-index tie-break keeps the grant one-hot.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (win[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_issue_scheduler.sv
// RS controller: allocates one free entry per cycle and issues the
// oldest ready entry per FU channel, registering the selection.
module rs_issue_scheduler
    import rs_issue_scheduler_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      squash,
    input  logic                      dispatch_req,
    input  logic [RS_SIZE-1:0]        entry_busy,
    input  logic [RS_SIZE-1:0]        entry_ready,
    input  logic [RS_SIZE*CH_W-1:0]   entry_ch,
    input  logic [NUM_CH-1:0]         fu_avail,
    output logic [RS_SIZE-1:0]        wr_en,
    output logic                      dispatch_ack,
    output logic                      rs_full,
    output logic [RS_SIZE-1:0]        clear,
    output logic [NUM_CH-1:0]         issue_valid,
    output logic [NUM_CH*IDX_W-1:0]   issue_idx
);

    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_q;
    logic [RS_SIZE-1:0][RS_SIZE-1:0] older_d;
    logic [CNT_W-1:0]                occ_cnt;
    logic [CNT_W-1:0]                occ_d;
    logic [NUM_CH-1:0][RS_SIZE-1:0]  cand;
    logic [NUM_CH-1:0][RS_SIZE-1:0]  grant;
    issue_sel_t [NUM_CH-1:0]         sel_d;
    issue_sel_t [NUM_CH-1:0]         sel_q;
    logic [RS_SIZE-1:0]              free_oh;
    logic                            kill;

    assign kill    = squash | reset;
    assign free_oh = ~entry_busy & (entry_busy + RS_SIZE'(1));
    assign rs_full = (occ_cnt == CNT_W'(RS_SIZE));

    assign dispatch_ack = dispatch_req & ~kill
                        & (occ_cnt < CNT_W'(RS_SIZE));
    assign wr_en = dispatch_ack ? free_oh : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        for (genvar i = 0; i < RS_SIZE; i++) begin : g_cand
            assign cand[c][i] = entry_busy[i] & entry_ready[i]
                & fu_avail[c]
                & (entry_ch[i*CH_W +: CH_W] == CH_W'(c));
        end

        rs_age_select u_sel (
            .cand  (cand[c]),
            .older (older_q),
            .grant (grant[c])
        );

        assign sel_d[c].valid = (|grant[c]) & ~kill;
        assign sel_d[c].idx   = kill ? '0 : oh_to_idx(grant[c]);
        assign issue_valid[c] = sel_q[c].valid;
        assign issue_idx[c*IDX_W +: IDX_W] = sel_q[c].idx;
    end

    always_comb begin
        clear = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            clear = clear | grant[c];
        end
        if (kill) clear = '0;
    end

    always_comb begin
        older_d = older_q;
        for (int k = 0; k < RS_SIZE; k++) begin
            if (wr_en[k]) begin
                older_d[k] = '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_d[j][k] = entry_busy[j];
                end
            end
        end
        // Issued entries drop out of the ordering entirely.
        for (int i = 0; i < RS_SIZE; i++) begin
            if (clear[i]) begin
                older_d[i] = '0;
                for (int j = 0; j < RS_SIZE; j++) begin
                    older_d[j][i] = 1'b0;
                end
            end
        end
    end

    assign occ_d = occ_cnt + CNT_W'(dispatch_ack)
                 - CNT_W'($countones(clear));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            older_q <= '0;
            occ_cnt <= '0;
            sel_q   <= '0;
        end else if (squash) begin
            older_q <= '0;
            occ_cnt <= '0;
            sel_q   <= '0;
        end else begin
            older_q <= older_d;
            occ_cnt <= occ_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with a behavioural RS
// busy-flag model driven from the scheduler's wr_en and clear.
module tb_rs_issue_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic        squash;
    logic        dispatch_req;
    logic [7:0]  busy;
    logic [7:0]  rdy;
    logic [15:0] chv;
    logic [3:0]  fu;
    logic [7:0]  wr_en;
    logic        dispatch_ack;
    logic        rs_full;
    logic [7:0]  clear;
    logic [3:0]  issue_valid;
    logic [11:0] issue_idx;

    int n_assert = 0;
    int n_fail   = 0;

    rs_issue_scheduler dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .dispatch_req (dispatch_req),
        .entry_busy   (busy),
        .entry_ready  (rdy),
        .entry_ch     (chv),
        .fu_avail     (fu),
        .wr_en        (wr_en),
        .dispatch_ack (dispatch_ack),
        .rs_full      (rs_full),
        .clear        (clear),
        .issue_valid  (issue_valid),
        .issue_idx    (issue_idx)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: the RS model latches wr_en/clear like the real array.
    task automatic tick();
        logic [7:0] w;
        logic [7:0] c;
        logic       s;
        w = wr_en;
        c = clear;
        s = squash;
        @(posedge clock);
        #1;
        busy = s ? 8'h00 : ((busy | w) & ~c);
        chk("occ_invariant", 32'(dut.occ_cnt), 32'($countones(busy)));
    endtask

    initial begin
        reset = 1'b1;
        squash = 1'b0;
        dispatch_req = 1'b0;
        busy = 8'h00;
        rdy = 8'h00;
        chv = 16'h0000;
        fu = 4'b0000;
        #2;
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_ack", 32'(dispatch_ack), 0);
        chk("rst_full", 32'(rs_full), 0);
        chk("rst_clear", 32'(clear), 0);
        chk("rst_ivalid", 32'(issue_valid), 0);
        chk("rst_iidx", 32'(issue_idx), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Fill all eight entries back to back.
        dispatch_req = 1'b1;
        settle();
        for (int k = 0; k < 8; k++) begin
            chk("fill_wr_en", 32'(wr_en), 32'(1) << k);
            chk("fill_ack", 32'(dispatch_ack), 1);
            chk("fill_full", 32'(rs_full), 0);
            tick();
            settle();
        end
        chk("full_flag", 32'(rs_full), 1);
        chk("full_ack", 32'(dispatch_ack), 0);
        chk("full_wr_en", 32'(wr_en), 0);
        dispatch_req = 1'b0;

        // Re-allocate 5 then 2 so 5 becomes the older of the two.
        rdy = 8'h20;
        fu = 4'b0001;
        settle();
        chk("free5_clear", 32'(clear), 32'h20);
        tick();
        chk("free5_ivalid", 32'(issue_valid), 1);
        chk("free5_iidx", 32'(issue_idx), 5);
        rdy = 8'h00;
        dispatch_req = 1'b1;
        settle();
        chk("alloc5_wr_en", 32'(wr_en), 32'h20);
        tick();
        dispatch_req = 1'b0;
        rdy = 8'h04;
        settle();
        chk("free2_clear", 32'(clear), 32'h04);
        tick();
        rdy = 8'h00;
        dispatch_req = 1'b1;
        settle();
        chk("alloc2_wr_en", 32'(wr_en), 32'h04);
        tick();
        dispatch_req = 1'b0;
        rdy = 8'h24;
        settle();
        chk("age_clear_5", 32'(clear), 32'h20);
        tick();
        chk("age_ivalid_5", 32'(issue_valid), 1);
        chk("age_iidx_5", 32'(issue_idx), 5);
        settle();
        chk("age_clear_2", 32'(clear), 32'h04);
        tick();
        chk("age_ivalid_2", 32'(issue_valid), 1);
        chk("age_iidx_2", 32'(issue_idx), 2);

        // ALU entry 1 and MULT entry 3 issue together.
        chv[7:6] = 2'd1;
        rdy = 8'h0A;
        fu = 4'b0011;
        settle();
        chk("dual_clear", 32'(clear), 32'h0A);
        tick();
        chk("dual_ivalid", 32'(issue_valid), 32'h3);
        chk("dual_iidx", 32'(issue_idx), 32'h019);
        rdy = 8'h00;
        fu = 4'b0000;

        // Refill free entries 1,2,3,5 in index order.
        dispatch_req = 1'b1;
        settle();
        chk("refill_wr_1", 32'(wr_en), 32'h02);
        tick();
        settle();
        chk("refill_wr_2", 32'(wr_en), 32'h04);
        tick();
        settle();
        chk("refill_wr_3", 32'(wr_en), 32'h08);
        tick();
        settle();
        chk("refill_wr_5", 32'(wr_en), 32'h20);
        tick();

        // Full RS: no bypass of the same-cycle issue of entry 4.
        rdy = 8'h10;
        fu = 4'b0001;
        settle();
        chk("nobyp_full", 32'(rs_full), 1);
        chk("nobyp_ack", 32'(dispatch_ack), 0);
        chk("nobyp_wr_en", 32'(wr_en), 0);
        chk("nobyp_clear", 32'(clear), 32'h10);
        tick();
        rdy = 8'h00;
        settle();
        chk("after_ack", 32'(dispatch_ack), 1);
        chk("after_wr_en", 32'(wr_en), 32'h10);
        chk("after_ivalid", 32'(issue_valid), 1);
        chk("after_iidx", 32'(issue_idx), 4);
        tick();
        dispatch_req = 1'b0;
        chk("after_occ", 32'(dut.occ_cnt), 8);

        // FU unavailable blocks issue; raising it issues the oldest.
        rdy = 8'h05;
        fu = 4'b0000;
        settle();
        chk("blk_clear", 32'(clear), 0);
        tick();
        chk("blk_ivalid", 32'(issue_valid), 0);
        fu = 4'b0001;
        settle();
        chk("unblk_clear", 32'(clear), 32'h01);
        tick();
        chk("unblk_ivalid", 32'(issue_valid), 1);
        chk("unblk_iidx", 32'(issue_idx), 0);

        // Drop to six busy entries, then squash.
        rdy = 8'h04;
        settle();
        chk("pre_sq_clear", 32'(clear), 32'h04);
        tick();
        chk("pre_sq_occ", 32'(dut.occ_cnt), 6);
        squash = 1'b1;
        dispatch_req = 1'b1;
        rdy = 8'h10;
        settle();
        chk("sq_wr_en", 32'(wr_en), 0);
        chk("sq_clear", 32'(clear), 0);
        tick();
        squash = 1'b0;
        rdy = 8'h00;
        chk("sq_occ", 32'(dut.occ_cnt), 0);
        chk("sq_ivalid", 32'(issue_valid), 0);
        chk("sq_full", 32'(rs_full), 0);
        settle();
        chk("post_sq_wr_0", 32'(wr_en), 32'h01);
        tick();
        settle();
        chk("post_sq_wr_1", 32'(wr_en), 32'h02);
        tick();
        dispatch_req = 1'b0;
        rdy = 8'h01;
        settle();
        chk("post_sq_clear", 32'(clear), 32'h01);
        tick();
        chk("post_sq_ivalid", 32'(issue_valid), 1);

        // Asynchronous reset in the middle of a cycle.
        reset = 1'b1;
        dispatch_req = 1'b1;
        rdy = 8'h02;
        settle();
        chk("arst_ivalid", 32'(issue_valid), 0);
        chk("arst_iidx", 32'(issue_idx), 0);
        chk("arst_wr_en", 32'(wr_en), 0);
        chk("arst_ack", 32'(dispatch_ack), 0);
        chk("arst_clear", 32'(clear), 0);
        chk("arst_occ", 32'(dut.occ_cnt), 0);
        busy = 8'h00;
        dispatch_req = 1'b0;
        rdy = 8'h00;
        @(posedge clock);
        #1;
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
